// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with synchronizer, framing-error and overrun reporting
module uart_rx #(
   parameter int DIVISOR = 10417
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial_in,
   input  logic       rx_read,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       rx_overrun,
   output logic       rx_frame_err
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
   localparam logic [15:0] HALF_M1 = 16'(DIVISOR / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(DIVISOR - 1);
   state_e      state_q, state_d;
   logic [1:0]  sync_q;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d, data_q, data_d;
   logic        valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
   logic        rxs, tick, accept;
   assign rxs = sync_q[1];
   // state register: synchronizer, FSM state, baud counter, bit index, shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], rx_serial_in};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end
   // next state: half-period wait to the start-bit centre, then full periods per bit
   always_comb begin
      tick    = cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1);
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs) state_d = START;
         end
         START: if (tick) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rxs ? IDLE : DATA;
         end
         DATA: if (tick) begin
            cnt_d          = '0;
            shift_d[idx_q] = rxs;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = STOP;
         end
         STOP: if (tick) begin
            cnt_d   = '0;
            state_d = rxs ? IDLE : BREAK;
         end
         BREAK: begin
            cnt_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end
   // outputs: accept on a high stop sample, error pulse on a low one
   always_comb begin
      accept  = (state_q == STOP) && tick && rxs;
      ferr_d  = (state_q == STOP) && tick && !rxs;
      data_d  = accept ? shift_q : data_q;
      valid_d = accept | (valid_q & ~rx_read);
      ovr_d   = ovr_q | (accept & valid_q & ~rx_read);
      rx_busy = state_q != IDLE;
   end
   // output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end
   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_overrun   = ovr_q;
   assign rx_frame_err = ferr_q;
endmodule
